// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Owns the PC, fetches over a variable-latency req/ack port, and applies stall/flush/redirect.
module if_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [31:0] startPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [1:0]  dbg_state
);

    // Fetch handshake: a request is open while imem_req=1 and imem_addr stays fixed
    // until the cycle imem_ack=1 completes it; imem_ack is ignored while imem_req=0.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_pc, pend_nxt;
    logic [31:0] skid_instr, skid_pc;
    logic        skid_we;
    logic        load_ifid;
    logic [31:0] load_instr, load_pc;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state   <= IDLE;
            pc      <= startPC;
            pend_pc <= 32'd0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        pend_nxt   = pend_pc;
        skid_we    = 1'b0;
        load_ifid  = 1'b0;
        load_instr = imem_rdata;
        load_pc    = pc;
        imem_req   = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redirect) begin
                        pc_nxt = redirect_pc;
                    end else if (!stall) begin
                        load_ifid = 1'b1;
                        pc_nxt    = pc + 32'd4;
                    end else begin
                        skid_we   = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = HOLD;
                    end
                end else if (redirect) begin
                    // The open request cannot be retargeted; finish it in DRAIN first.
                    pend_nxt  = redirect_pc;
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    load_ifid  = 1'b1;
                    load_instr = skid_instr;
                    load_pc    = skid_pc;
                    state_nxt  = FETCH;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_nxt    = redirect ? redirect_pc : pend_pc;
                    state_nxt = FETCH;
                end else if (redirect) begin
                    pend_nxt = redirect_pc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign dbg_state = state;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            skid_instr <= 32'd0;
            skid_pc    <= 32'd0;
        end else if (skid_we) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
        end
    end

    // Flush wins over stall, stall over a new load; with nothing to load, insert a bubble.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            ifid_valid    <= 1'b0;
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= 32'd0;
            ifid_pc_plus4 <= 32'd0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end else if (stall) begin
            ifid_valid <= ifid_valid;
        end else if (load_ifid) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= load_instr;
            ifid_pc       <= load_pc;
            ifid_pc_plus4 <= load_pc + 32'd4;
        end else begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a transaction-level fetch model predicts
// which words reach decode; a monitor checks every IF/ID presentation against it.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        CLK;
    logic        Reset_L;
    logic [31:0] startPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [1:0]  dbg_state;

    if_stage #(.NOP_INSTR(NOP)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pc_plus4(ifid_pc_plus4), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0;
    int n_err = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];           // addresses of words expected to enter IF/ID, in order
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] last_pc = 32'd0;

    // Transaction-level fetch model
    logic        m_req_on;           // a request should be on the bus
    logic [31:0] m_fetch_pc;         // address of the open / next request
    logic        m_doomed;           // open request was overtaken by a redirect
    logic [31:0] m_target;           // where fetching resumes after a doomed request
    logic        m_waiting;          // fetched word parked while decode is stalled
    logic [31:0] m_w_pc;
    int          lat_left, lat_min, lat_max;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3 ^ (a * 32'd3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [31:0] spc);
        startPC   = spc;
        Reset_L   = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        redirect  = 1'b0;
        imem_ack  = 1'b1;            // a stray ack around reset must be ignored
        imem_rdata = $urandom;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc", ifid_pc, 32'd0);
        chk("rst_pc4", ifid_pc_plus4, 32'd0);
        exp_q.delete();
        m_req_on   = 1'b0;
        m_fetch_pc = spc;
        m_doomed   = 1'b0;
        m_waiting  = 1'b0;
        repeat (2) @(negedge CLK);
        Reset_L = 1'b1;
        #1;
        chk("idle_req", 32'(imem_req), 32'd0);
        mon_en   = 1'b1;
        m_req_on = 1'b1;             // the first edge after release starts fetching
        lat_left = int'($urandom_range(lat_max, lat_min));
    endtask

    // ack_mode: 0 = withhold ack, 1 = ack after random latency, 2 = ack now
    task automatic step(input logic s, input logic f, input logic r,
                        input logic [31:0] rpc, input int ack_mode);
        logic a;
        @(posedge CLK);
        #1;
        chk("imem_req", 32'(imem_req), 32'(m_req_on));
        if (m_req_on) chk("imem_addr", imem_addr, m_fetch_pc);
        if (m_req_on) begin
            if (ack_mode == 0)      a = 1'b0;
            else if (ack_mode == 2) a = 1'b1;
            else                    a = (lat_left == 0);
            if (ack_mode == 1 && !a) lat_left--;
        end else begin
            a = 1'($urandom_range(0, 1));
        end
        stall       = s;
        flush       = f;
        redirect    = r;
        redirect_pc = rpc;
        imem_ack    = a;
        imem_rdata  = (m_req_on && a) ? mem_word(m_fetch_pc) : $urandom;

        if (m_req_on) begin
            if (a) begin
                lat_left = int'($urandom_range(lat_max, lat_min));
                if (m_doomed) begin
                    m_doomed   = 1'b0;
                    m_fetch_pc = r ? rpc : m_target;
                end else if (r) begin
                    m_fetch_pc = rpc;
                end else if (s) begin
                    m_waiting  = 1'b1;
                    m_w_pc     = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                    m_req_on   = 1'b0;
                end else begin
                    if (!f) exp_q.push_back(m_fetch_pc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end else if (r) begin
                m_doomed = 1'b1;
                m_target = rpc;
            end
        end else if (m_waiting) begin
            if (r) begin
                m_waiting  = 1'b0;
                m_fetch_pc = rpc;
                m_req_on   = 1'b1;
            end else if (!s) begin
                if (!f) exp_q.push_back(m_w_pc);
                m_waiting = 1'b0;
                m_req_on  = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 5) == 0) return 32'hFFFF_FFF8;
        return 32'($urandom_range(0, 32'h0000_FFFF)) & 32'hFFFF_FFFC;
    endfunction

    // ---------------- monitor ----------------
    always @(posedge CLK) prev_stall <= stall;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (ifid_valid) begin
                if (!prev_stall) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL ifid_unexpected: got pc %h, want no instruction", ifid_pc);
                    end else begin
                        last_pc = exp_q.pop_front();
                    end
                end
                chk("ifid_instr", ifid_instr, mem_word(last_pc));
                chk("ifid_pc", ifid_pc, last_pc);
                chk("ifid_pc_plus4", ifid_pc_plus4, last_pc + 32'd4);
            end else begin
                chk("ifid_bubble", ifid_instr, NOP);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        Reset_L = 1'b1;
        startPC = 32'd0;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        lat_min = 0; lat_max = 0; lat_left = 0;
        m_req_on = 1'b0; m_fetch_pc = 32'd0; m_doomed = 1'b0; m_target = 32'd0;
        m_waiting = 1'b0; m_w_pc = 32'd0;
        #2;

        // single-cycle memory: one instruction per cycle
        do_reset(32'h0040_0000);
        repeat (12) step(1'b0, 1'b0, 1'b0, 32'd0, 2);

        // fixed 3-cycle latency: bubbles between instructions
        lat_min = 3; lat_max = 3;
        repeat (20) step(1'b0, 1'b0, 1'b0, 32'd0, 1);

        // long stall across an ack
        step(1'b1, 1'b0, 1'b0, 32'd0, 2);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0, 1);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0, 1);

        // random mix of latency, stalls, flushes and redirects
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), rand_target(), 1);
        end

        // redirect while a request to 0x20 is still open
        lat_min = 3; lat_max = 3;
        do_reset(32'h0000_0020);
        step(1'b0, 1'b0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 2);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 2);

        // flush + stall + ack together: word parks, then delivers after stall drops
        step(1'b1, 1'b1, 1'b0, 32'd0, 2);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 2);

        // PC wrap at the top of the address space
        lat_min = 0; lat_max = 0;
        do_reset(32'hFFFF_FFF8);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0, 2);

        // async reset while draining a redirected request
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0300, 0);
        @(posedge CLK);
        #1;
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_addr", imem_addr, m_fetch_pc);
        imem_ack = 1'b1;
        #2;
        lat_min = 0; lat_max = 2;
        do_reset(32'h0000_1000);
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'd0, 1);

        @(negedge CLK);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
